cswap_serial_adder: RTL and testbench

CSWAP_SERIAL_ADDER -- requirements
Module: cswap_serial_adder

---
 rtl/cswap_serial_adder_pkg.sv | 24 ++
 rtl/cswap_serial_adder_fa.sv | 37 +++
 rtl/cswap_serial_adder.sv | 108 ++++++++++
 tb/tb_cswap_serial_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cswap_serial_adder_pkg.sv
// rtl/cswap_serial_adder_pkg.sv - shared types, mode constants and controlled-swap helper
//
// Purpose: FSM state type, add/sub mode encodings and the Fredkin gate
//          primitive used by the bit-serial adder and its full-adder cell.
// Ports:   none (package).

package cswap_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Fredkin (controlled-swap) gate: control passes through unchanged,
    // x and y are exchanged when c is high. Returns {x_out, y_out}.
    function automatic logic [1:0] cswap(input logic c, input logic x, input logic y);
        return c ? {y, x} : {x, y};
    endfunction

endpackage

// File: rtl/cswap_serial_adder_fa.sv
// rtl/cswap_serial_adder_fa.sv - 1-bit full adder built only from controlled-swap gates
//
// Purpose: reversible-logic full adder; constant 0/1 ancillas provide fan-out
//          and inversion, garbage outputs are discarded.
// Ports:   a, b, cin  - addend bits and carry in
//          sum, carry - sum bit and carry out

module cswap_fa
    import cswap_serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic [1:0] g_b;
    logic [1:0] g_p;
    logic [1:0] g_s;
    logic [1:0] g_c;
    logic       unused_garbage;

    // Ancillas (0,1) controlled by b yield {b, ~b}.
    assign g_b = cswap(b, 1'b0, 1'b1);
    // Controlled by a: {a ^ b, ~(a ^ b)}.
    assign g_p = cswap(a, g_b[1], g_b[0]);
    // Controlled by cin: first output is propagate ^ cin.
    assign g_s = cswap(cin, g_p[1], g_p[0]);
    // Controlled by propagate: carry = p ? cin : a (a == b when p is low).
    assign g_c = cswap(g_p[1], a, cin);

    assign sum            = g_s[1];
    assign carry          = g_c[1];
    assign unused_garbage = g_s[0] ^ g_c[0];

endmodule

// File: rtl/cswap_serial_adder.sv
// rtl/cswap_serial_adder.sv - bit-serial adder/subtractor around a single Fredkin full adder
//
// Purpose: one bit per cycle, LSB first; W+1 cycles from accepted start to done.
// Ports:   clk, rst_n (sync, active-low)
//          start, sub, a, b - request, mode (0 add / 1 sub) and operands
//          busy             - operation in progress
//          done             - one-cycle pulse when sum/cout/ovf update
//          sum, cout, ovf   - result, carry out of MSB, signed overflow

module cswap_serial_adder
    import cswap_serial_adder_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [W-1:0]  res_next;
    logic          carry;
    logic [CW-1:0] count;
    logic          fa_sum;
    logic          fa_carry;
    logic          last;
    logic          accept;

    cswap_fa u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign last     = (count == CW'(W - 1));
    assign accept   = start && (state != RUN);
    // New sum bit enters from the MSB side so that after W shifts the
    // first (LSB) result bit has reached bit 0.
    assign res_next = W'({fa_sum, res_sr} >> 1);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
            a_sr   <= a;
            b_sr   <= (sub == ADD) ? b : ~b;
            carry  <= (sub == SUB);
            count  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            carry  <= fa_carry;
            count  <= count + 1'b1;
            if (last) begin
                sum  <= res_next;
                cout <= fa_carry;
                // On the MSB cycle, carry holds the carry into the MSB.
                ovf  <= carry ^ fa_carry;
            end
        end
    end

endmodule

// File: tb/tb_cswap_serial_adder.sv
// tb/tb_cswap_serial_adder.sv - randomized self-checking bench for cswap_serial_adder

module tb_cswap_serial_adder;

    typedef struct {
        longint unsigned sum;
        bit              cout;
        bit              ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start1, sub1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp8;

    always #5 clk = ~clk;

    cswap_serial_adder #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    cswap_serial_adder #(.W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Integer-level reference: wrap the unsigned result to w bits, and flag
    // overflow when the true signed result leaves the w-bit signed range.
    function automatic res_t model(input int w, input longint unsigned a,
                                   input longint unsigned b, input bit s);
        res_t            r;
        longint unsigned mask, full;
        longint          sa, sb, t, hi, lo;
        mask   = (64'd1 << w) - 64'd1;
        full   = a + (s ? (~b & mask) : b) + {63'd0, s};
        r.sum  = full & mask;
        r.cout = ((full >> w) & 64'd1) != 0;
        sa = longint'(a);
        sb = longint'(b);
        if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
        if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
        t  = s ? sa - sb : sa + sb;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        r.ovf = (t > hi) || (t < lo);
        return r;
    endfunction

    task automatic check_res8(input string tag, input res_t m);
        check({tag, "_sum"},  {56'd0, sum8}, m.sum);
        check({tag, "_cout"}, {63'd0, cout8}, {63'd0, m.cout});
        check({tag, "_ovf"},  {63'd0, ovf8},  {63'd0, m.ovf});
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit poke);
        res_t m;
        int   lat;
        m = model(8, a, b, s);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
            end
            if (poke && k == 3) start8 = 1'b1;
            if (poke && k == 4) start8 = 1'b0;
            if (done8) begin
                lat = k;
                break;
            end
            check("busy_run", {63'd0, busy8}, 64'd1);
            check("hold_sum", {56'd0, sum8}, exp8.sum);
        end
        check("latency", lat, 9);
        check_res8("op8", m);
        check("done_busy", {63'd0, busy8}, 64'd0);
        exp8 = m;
        @(negedge clk);
        check("done_single", {63'd0, done8}, 64'd0);
        check("idle_busy", {63'd0, busy8}, 64'd0);
    endtask

    task automatic b2b8(input logic [7:0] a_1, input logic [7:0] b_1, input logic s_1,
                        input logic [7:0] a_2, input logic [7:0] b_2, input logic s_2);
        res_t m1, m2;
        int   lat;
        m1 = model(8, a_1, b_1, s_1);
        m2 = model(8, a_2, b_2, s_2);
        @(negedge clk);
        start8 = 1'b1; a8 = a_1; b8 = b_1; sub8 = s_1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            // start stays high; second operands wait for the DONE cycle.
            if (k == 1) begin a8 = a_2; b8 = b_2; sub8 = s_2; end
            if (done8) begin lat = k; break; end
        end
        check("b2b_lat1", lat, 9);
        check_res8("b2b1", m1);
        exp8 = m1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
            if (done8) begin lat = k; break; end
            check("b2b_busy", {63'd0, busy8}, 64'd1);
        end
        check("b2b_gap", lat, 9);
        check_res8("b2b2", m2);
        exp8 = m2;
        @(negedge clk);
        check("b2b_single", {63'd0, done8}, 64'd0);
    endtask

    task automatic op1(input logic a, input logic b, input logic s);
        res_t m;
        int   lat;
        m = model(1, {63'd0, a}, {63'd0, b}, s);
        @(negedge clk);
        start1 = 1'b1; a1 = a; b1 = b; sub1 = s;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); sub1 = 1'($urandom);
            end
            if (done1) begin lat = k; break; end
        end
        check("w1_latency", lat, 2);
        check("w1_sum",  {63'd0, sum1},  m.sum);
        check("w1_cout", {63'd0, cout1}, {63'd0, m.cout});
        check("w1_ovf",  {63'd0, ovf1},  {63'd0, m.ovf});
    endtask

    initial begin
        bit saw_done;
        rst_n  = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        exp8   = '{sum: 0, cout: 1'b0, ovf: 1'b0};
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_done", {63'd0, done8}, 64'd0);
        check("rst_sum",  {56'd0, sum8},  64'd0);
        check("rst_cout", {63'd0, cout8}, 64'd0);
        check("rst_ovf",  {63'd0, ovf8},  64'd0);
        check("rst_w1",   {60'd0, busy1, done1, cout1, ovf1}, 64'd0);
        rst_n = 1'b1;

        op8(8'h7F, 8'h01, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 1'b1, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b1);
        b2b8(8'h12, 8'h34, 1'b0, 8'h05, 8'h09, 1'b1);

        // Abort mid-run, with start asserted alongside reset.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h33; sub8 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
        end
        rst_n = 1'b0; start8 = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_done", {63'd0, done8}, 64'd0);
        check("abort_sum",  {56'd0, sum8},  64'd0);
        check("abort_flags", {62'd0, cout8, ovf8}, 64'd0);
        rst_n = 1'b1; start8 = 1'b0;
        exp8 = '{sum: 0, cout: 1'b0, ovf: 1'b0};
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1'b1;
        end
        check("abort_quiet", {63'd0, saw_done}, 64'd0);
        op8(8'h55, 8'h33, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 8; i++) begin
            op1(i[2], i[1], i[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
